lsu_bus_adapter: RTL and testbench

- Load/store unit that sits directly downstream of the decoder/control stage and consumes its memory control fields: mem_valid, mem_write, mem_size, load_zero_extend.
- Converts one core memory access into a request/grant/response transaction on the data bus.
- Stalls the single-cycle core until the access completes.
- Returns sign- or zero-extended load data for the WB_SRC_MEM writeback path, and flags misaligned, illegal-size and timed-out accesses.

---
 rtl/lsu_bus_adapter.sv | 94 +++++++++
 tb/tb_lsu_bus_adapter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter: turns one core load/store into a req/gnt/rvalid bus transaction, stalling the core until done
module lsu_bus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_zero_extend,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;
  state_t state, state_n;
  logic        we_q, zext_q, fault_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [15:0] cnt;
  logic        bad, timeout;
  logic [31:0] rsh, ext, wdata_rep;
  logic [3:0]  be;
  assign bad = (req_size == 2'b10) || (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b11 && req_addr[1:0] != 2'b00);
  // cnt counts completed REQ/WAIT_R cycles, so this fires on the TIMEOUT_CYCLES-th one
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt >= 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = req_valid ? (bad ? DONE : REQ) : IDLE;
      REQ:    state_n = bus_gnt ? (we_q ? DONE : WAIT_R) : (timeout ? DONE : REQ);
      WAIT_R: state_n = (bus_rvalid || timeout) ? DONE : WAIT_R;
      DONE:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q    <= 1'b0;
      zext_q  <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      cnt     <= '0;
    end else if (state == IDLE && req_valid) begin
      we_q    <= req_write;
      zext_q  <= req_zero_extend;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      fault_q <= bad;
      data_q  <= '0;
      cnt     <= '0;
    end else if (state == REQ || state == WAIT_R) begin
      cnt <= cnt + 16'd1;
      if (state == WAIT_R && bus_rvalid) data_q <= ext;
      else if (timeout && !(state == REQ && bus_gnt)) begin
        fault_q <= 1'b1;
        data_q  <= '0;
      end
    end
  assign rsh = bus_rdata >> {addr_q[1:0], 3'b000};
  assign ext = size_q == 2'b11 ? bus_rdata :
               size_q == 2'b01 ? {zext_q ? 16'h0 : {16{rsh[15]}}, rsh[15:0]} :
                                 {zext_q ? 24'h0 : {24{rsh[7]}}, rsh[7:0]};
  assign be = size_q == 2'b11 ? 4'hf : (size_q == 2'b01 ? 4'b0011 : 4'b0001) << addr_q[1:0];
  assign wdata_rep = size_q == 2'b11 ? wdata_q :
                     size_q == 2'b01 ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  assign bus_req   = state == REQ;
  assign bus_we    = bus_req && we_q;
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus_be    = bus_req ? be : '0;
  assign bus_wdata = bus_req ? wdata_rep : '0;
  assign stall     = req_valid && state != DONE;
  assign done      = state == DONE;
  assign load_data = done ? data_q : '0;
  assign fault     = done && fault_q;
endmodule

// File: tb/tb_lsu_bus_adapter.sv
// tb_lsu_bus_adapter: table-driven transactions with a done-time scoreboard, plus reset and timeout sequences
module tb_lsu_bus_adapter;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic        req_valid = 0, req_write = 0, req_zero_extend = 0, t_valid = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, bus_rdata = 0;
  logic        bus_gnt = 0, bus_rvalid = 0;
  logic        stall, done, fault, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        t_stall, t_done, t_fault, t_bus_req, t_bus_we;
  logic [31:0] t_load_data, t_bus_addr, t_bus_wdata;
  logic [3:0]  t_bus_be;
  int checks = 0, passed = 0;

  lsu_bus_adapter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_zero_extend(req_zero_extend), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .load_data(load_data), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata));

  lsu_bus_adapter #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .req_valid(t_valid), .req_write(req_write), .req_size(req_size),
    .req_zero_extend(req_zero_extend), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(t_stall), .done(t_done), .load_data(t_load_data), .fault(t_fault),
    .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_addr(t_bus_addr), .bus_be(t_bus_be), .bus_wdata(t_bus_wdata),
    .bus_gnt(1'b0), .bus_rvalid(1'b0), .bus_rdata(32'h0));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct { logic f; logic [31:0] ld; } res_t;
  res_t sb[$];
  res_t e;
  always @(negedge clk)
    if (rst_n && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("fault", {63'h0, fault}, {63'h0, e.f});
        chk("load_data", {32'h0, load_data}, {32'h0, e.ld});
      end
    end

  typedef struct {
    logic w; logic [1:0] size; logic z; logic [31:0] addr, wdata, rdata;
    int gd, rd; logic [3:0] be; logic [31:0] wexp; logic f; logic [31:0] ld;
  } vec_t;
  vec_t tv[13];

  task automatic run(input int i, input vec_t v);
    int cyc = 0, rq = 0, wq = 0;
    bit granted = 0, seen = 0, stall_ok = 1, fin = 0;
    int exp_lat = v.f ? 1 : (v.w ? v.gd + 2 : v.gd + v.rd + 3);
    sb.push_back('{v.f, v.ld});
    @(negedge clk);
    req_write = v.w; req_size = v.size; req_zero_extend = v.z;
    req_addr = v.addr; req_wdata = v.wdata; bus_rdata = v.rdata; req_valid = 1;
    while (!fin && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        fin = 1;
        stall_ok &= !stall;
      end else begin
        stall_ok &= stall;
        if (bus_req) begin
          if (!seen && !v.f) begin
            chk($sformatf("v%0d_we_be", i), {59'h0, bus_we, bus_be}, {59'h0, v.w, v.be});
            chk($sformatf("v%0d_addr", i), {32'h0, bus_addr}, {32'h0, v.addr[31:2], 2'b00});
            if (v.w) chk($sformatf("v%0d_wdata", i), {32'h0, bus_wdata}, {32'h0, v.wexp});
          end
          seen = 1;
          bus_gnt = (rq == v.gd);
          granted |= bus_gnt;
          rq++;
        end else begin
          bus_gnt = 0;
          if (granted) begin
            bus_rvalid = (wq == v.rd);
            wq++;
          end
        end
      end
    end
    if (!fin) begin
      chk($sformatf("v%0d_done_wait", i), 0, 1);
      void'(sb.pop_front());
    end
    chk($sformatf("v%0d_bus_seen", i), {63'h0, seen}, {63'h0, !v.f});
    chk($sformatf("v%0d_latency", i), 64'(cyc), 64'(exp_lat));
    chk($sformatf("v%0d_stall", i), {63'h0, stall_ok}, 64'h1);
    req_valid = 0; bus_gnt = 0; bus_rvalid = 0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit ok;
    tv[0]  = '{1, 2'b11, 0, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0};
    tv[1]  = '{1, 2'b00, 0, 32'h1000_0003, 32'h0000_00A5, 32'h0, 0, 0, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0};
    tv[2]  = '{0, 2'b00, 0, 32'h1000_0002, 32'h0, 32'h0080_0000, 0, 0, 4'b0100, 32'h0, 0, 32'hFFFF_FF80};
    tv[3]  = '{0, 2'b00, 1, 32'h1000_0002, 32'h0, 32'h0080_0000, 0, 0, 4'b0100, 32'h0, 0, 32'h0000_0080};
    tv[4]  = '{0, 2'b01, 0, 32'h1000_0001, 32'h0, 32'hFFFF_FFFF, 0, 0, 4'b0000, 32'h0, 1, 32'h0};
    tv[5]  = '{0, 2'b11, 0, 32'h2000_0000, 32'h0, 32'h1234_5678, 3, 1, 4'b1111, 32'h0, 0, 32'h1234_5678};
    tv[6]  = '{1, 2'b01, 0, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 1, 0, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0};
    tv[7]  = '{0, 2'b01, 0, 32'h0000_0102, 32'h0, 32'h8001_0000, 0, 0, 4'b1100, 32'h0, 0, 32'hFFFF_8001};
    tv[8]  = '{0, 2'b01, 1, 32'h0000_0102, 32'h0, 32'h8001_0000, 0, 0, 4'b1100, 32'h0, 0, 32'h0000_8001};
    tv[9]  = '{0, 2'b10, 0, 32'h0000_0200, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1, 32'h0};
    tv[10] = '{1, 2'b11, 0, 32'h0000_0202, 32'h1111_2222, 32'h0, 0, 0, 4'b0000, 32'h0, 1, 32'h0};
    tv[11] = '{0, 2'b11, 1, 32'h0000_0300, 32'h0, 32'h8000_0000, 1, 0, 4'b1111, 32'h0, 0, 32'h8000_0000};
    tv[12] = '{0, 2'b00, 0, 32'h0000_0301, 32'h0, 32'h0000_7F00, 0, 2, 4'b0010, 32'h0, 0, 32'h0000_007F};
    #2 rst_n = 0;
    #1;
    chk("reset_ctl", {56'h0, stall, done, fault, bus_req, bus_we, t_bus_req, t_done, t_fault}, 64'h0);
    chk("reset_be_ld", {28'h0, bus_be, load_data}, 64'h0);
    chk("reset_addr_wdata", {bus_addr, bus_wdata}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) run(i, tv[i]);
    // response arriving with no transaction outstanding
    ok = 1;
    bus_rvalid = 1; bus_rdata = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      ok &= !done && !stall && !bus_req;
    end
    bus_rvalid = 0;
    chk("idle_rvalid_ignored", {63'h0, ok}, 64'h1);
    // reset while waiting for a read response
    req_write = 0; req_size = 2'b11; req_zero_extend = 0; req_addr = 32'h0000_0040;
    req_valid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_req && n < 10);
    chk("rst_seq_req", {63'h0, bus_req}, 64'h1);
    bus_gnt = 1;
    @(negedge clk);
    bus_gnt = 0;
    chk("rst_seq_wait_r", {62'h0, bus_req, stall}, 64'h1);
    rst_n = 0; req_valid = 0;
    #1;
    chk("rst_mid_ctl", {59'h0, stall, done, fault, bus_req, bus_we}, 64'h0);
    chk("rst_mid_data", {28'h0, bus_be, load_data}, 64'h0);
    chk("rst_mid_addr", {bus_addr, bus_wdata}, 64'h0);
    @(negedge clk);
    rst_n = 1;
    bus_rvalid = 1; bus_rdata = 32'h5555_AAAA;
    ok = 1;
    repeat (3) begin
      @(negedge clk);
      ok &= !done && !fault && load_data == 32'h0;
    end
    bus_rvalid = 0;
    chk("late_rvalid_ignored", {63'h0, ok}, 64'h1);
    // timeout instance never sees a grant
    req_write = 0; req_size = 2'b11; req_addr = 32'h0000_0080;
    @(negedge clk);
    t_valid = 1;
    n = 0;
    for (int c = 0; c < 20 && !t_done; c++) begin
      @(negedge clk);
      if (t_bus_req) n++;
    end
    chk("timeout_done", {63'h0, t_done}, 64'h1);
    chk("timeout_req_cycles", 64'(n), 64'd4);
    chk("timeout_fault", {63'h0, t_fault}, 64'h1);
    chk("timeout_ld_req", {31'h0, t_bus_req, t_load_data}, 64'h0);
    chk("timeout_stall", {63'h0, t_stall}, 64'h0);
    t_valid = 0;
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
